// File: rtl/mem_stage_bus_pkg.sv
// Shared encodings for the MEM stage: write-back source select and peripheral register offsets.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_stage_bus_pkg;

   // Write-back source select carried on MemtoReg; the fourth code behaves like ALU.
   typedef enum logic [1:0] {
      MTR_ALU  = 2'b00,
      MTR_MEM  = 2'b01,
      MTR_JAL  = 2'b10,
      MTR_RSVD = 2'b11
   } mtr_e;

   // Byte offsets of the peripheral registers from the window base.
   localparam logic [4:0] OFF_TH      = 5'h00;
   localparam logic [4:0] OFF_TL      = 5'h04;
   localparam logic [4:0] OFF_TCON    = 5'h08;
   localparam logic [4:0] OFF_LED     = 5'h0C;
   localparam logic [4:0] OFF_DIGI    = 5'h10;
   localparam logic [4:0] OFF_SYSTICK = 5'h14;

   // Size of the decoded peripheral window in bytes (six word registers).
   localparam logic [31:0] PERIPH_SPAN = 32'h18;

endpackage

// File: rtl/mem_stage_bus_periph_timer.sv
// Peripheral register block: reload timer (TH/TL/TCON), free-running systick, LED and 7-seg registers.
// Latency: reads are combinational on offset; writes take effect at the next rising edge.
// Backpressure: none, a write is always accepted in the cycle it is presented.
// Ports: clk/reset (sync, active-high); wr_en + offset + wdata form the CPU write, already qualified
//        by the window decode; rdata is the read mux on offset; leds/digits/irq are the visible outputs.
module periph_timer
   import mem_stage_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [4:0]  offset,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [7:0]  leds,
   output logic [11:0] digits,
   output logic        irq
);

   logic [31:0] th;
   logic [31:0] tl;
   logic [2:0]  tcon;
   logic [31:0] systick;

   logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
   logic overflow;
   logic ovf_set;

   assign wr_th   = wr_en && (offset == OFF_TH);
   assign wr_tl   = wr_en && (offset == OFF_TL);
   assign wr_tcon = wr_en && (offset == OFF_TCON);
   assign wr_led  = wr_en && (offset == OFF_LED);
   assign wr_digi = wr_en && (offset == OFF_DIGI);

   // Counting timer at terminal count reloads this edge; the sticky flag only latches when armed.
   assign overflow = tcon[0] && (tl == 32'hFFFF_FFFF);
   assign ovf_set  = overflow && tcon[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         th      <= '0;
         tl      <= '0;
         tcon    <= '0;
         systick <= '0;
         leds    <= '0;
         digits  <= '0;
      end else begin
         systick <= systick + 32'd1;

         // TH takes the new value while the reload below still sees the old one.
         if (wr_th) th <= wdata;

         // CPU write to TL beats both increment and reload.
         if (wr_tl)
            tl <= wdata;
         else if (overflow)
            tl <= th;
         else if (tcon[0])
            tl <= tl + 32'd1;

         if (wr_tcon) tcon[1:0] <= wdata[1:0];

         // Bit 2 is set by hardware, cleared only by writing 0; a coincident set wins.
         if (ovf_set)
            tcon[2] <= 1'b1;
         else if (wr_tcon && !wdata[2])
            tcon[2] <= 1'b0;

         if (wr_led)  leds   <= wdata[7:0];
         if (wr_digi) digits <= wdata[11:0];
      end
   end

   always_comb begin
      rdata = '0;
      case (offset)
         OFF_TH:      rdata = th;
         OFF_TL:      rdata = tl;
         OFF_TCON:    rdata = {29'd0, tcon};
         OFF_LED:     rdata = {24'd0, leds};
         OFF_DIGI:    rdata = {20'd0, digits};
         OFF_SYSTICK: rdata = systick;
         default:     rdata = '0;
      endcase
   end

   assign irq = tcon[1] & tcon[2];

endmodule

// File: rtl/mem_stage_bus.sv
// MEM stage: word load/store to data RAM and peripheral window, write-back select, MEM/WB register.
// Latency: load/ALU/link value reaches WB outputs 1 cycle later; MEM_fwd_data is combinational.
// Backpressure: none, no stall or flush; every edge advances MEM/WB.
// Ports: MEM_* are the EX/MEM register outputs; WB_* are the registered MEM/WB outputs;
//        leds/digits/irq come from the peripheral block.
module mem_stage_bus
   import mem_stage_bus_pkg::*;
#(
   parameter int          RAM_WORDS   = 256,
   parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        MEM_Mem_wr,
   input  logic [1:0]  MEM_MemtoReg,
   input  logic        MEM_RegWr,
   input  logic [31:0] MEM_ALUout,
   input  logic [31:0] MEM_rt_data,
   input  logic [4:0]  MEM_Write_register,
   input  logic [31:0] MEM_PC_jal,
   output logic [31:0] MEM_fwd_data,
   output logic        WB_RegWr,
   output logic [4:0]  WB_Write_register,
   output logic [31:0] WB_write_data,
   output logic [7:0]  leds,
   output logic [11:0] digits,
   output logic        irq
);

   localparam int          AW        = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

   logic [31:0] ram [RAM_WORDS];

   logic [31:0] word_addr;
   logic [31:0] periph_off;
   logic        ram_hit;
   logic        periph_hit;
   logic [31:0] periph_rdata;
   logic [31:0] load_data;
   logic [31:0] wb_src;
   logic [AW-1:0] ram_idx;

   assign word_addr  = {MEM_ALUout[31:2], 2'b00};
   // Addresses below the base wrap to a huge offset and fall outside the span.
   assign periph_off = word_addr - PERIPH_BASE;
   assign ram_hit    = MEM_ALUout < RAM_BYTES;
   assign periph_hit = !ram_hit && (periph_off < PERIPH_SPAN);
   assign ram_idx    = MEM_ALUout[AW+1:2];

   // RAM has no reset; reset still blocks a store on its edge.
   always_ff @(posedge clk) begin
      if (!reset && MEM_Mem_wr && ram_hit) ram[ram_idx] <= MEM_rt_data;
   end

   periph_timer u_periph (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (MEM_Mem_wr && periph_hit),
      .offset (periph_off[4:0]),
      .wdata  (MEM_rt_data),
      .rdata  (periph_rdata),
      .leds   (leds),
      .digits (digits),
      .irq    (irq)
   );

   always_comb begin
      load_data = '0;
      if (ram_hit)
         load_data = ram[ram_idx];
      else if (periph_hit)
         load_data = periph_rdata;
   end

   assign MEM_fwd_data = (mtr_e'(MEM_MemtoReg) == MTR_JAL) ? MEM_PC_jal : MEM_ALUout;

   always_comb begin
      wb_src = MEM_ALUout;
      case (mtr_e'(MEM_MemtoReg))
         MTR_MEM: wb_src = load_data;
         MTR_JAL: wb_src = MEM_PC_jal;
         default: wb_src = MEM_ALUout;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         WB_RegWr          <= 1'b0;
         WB_Write_register <= '0;
         WB_write_data     <= '0;
      end else begin
         WB_RegWr          <= MEM_RegWr;
         WB_Write_register <= MEM_Write_register;
         WB_write_data     <= wb_src;
      end
   end

endmodule
